// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: one-request-at-a-time load/store controller between the CPU
// datapath and a word-only data memory. Handles word/halfword/byte loads with
// sign/zero extension and does sub-word stores as read-modify-write. Flags
// misaligned and out-of-range addresses without touching memory.
//
// Handshake: a request is taken on any rising clk edge where o_ready=1 and
// i_req=1 (o_ready is high only in IDLE). i_req is ignored, not queued,
// while busy. o_done pulses for exactly one cycle per accepted request.
// o_addr_err and o_rdata are valid with o_done and are held until the next
// accept.
module dm_access_ctrl #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_addr_err,
    output logic        o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_din,
    input  logic [31:0] i_dm_dout,
    output logic [1:0]  o_state
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_done;
    logic        r_addr_err;
    logic [31:0] r_rdata;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_word;

    logic        w_out_of_range;
    logic        w_misaligned;
    logic        w_is_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    assign w_out_of_range = |i_addr[31:ADDR_BITS];
    assign w_is_load      = (r_op <= OP_LBU);

    // Alignment check of the incoming request, decoded from the live op.
    always_comb begin
        w_misaligned = 1'b0;
        case (i_op)
            OP_LW, OP_SW:         w_misaligned = |i_addr[1:0];
            OP_LH, OP_LHU, OP_SH: w_misaligned = i_addr[0];
            default:              w_misaligned = 1'b0;
        endcase
    end

    // Lane selection and extension of the word read back from memory.
    always_comb begin
        w_byte     = 8'h00;
        w_half     = r_addr[1] ? i_dm_dout[31:16] : i_dm_dout[15:0];
        w_load_val = 32'h0;
        case (r_addr[1:0])
            2'd0:    w_byte = i_dm_dout[7:0];
            2'd1:    w_byte = i_dm_dout[15:8];
            2'd2:    w_byte = i_dm_dout[23:16];
            default: w_byte = i_dm_dout[31:24];
        endcase
        case (r_op)
            OP_LW:   w_load_val = i_dm_dout;
            OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_val = {16'h0, w_half};
            OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_val = {24'h0, w_byte};
            default: w_load_val = 32'h0;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lane, keep the rest.
    always_comb begin
        w_merged = i_dm_dout;
        if (r_op == OP_SH) begin
            if (r_addr[1]) w_merged[31:16] = r_word[15:0];
            else           w_merged[15:0]  = r_word[15:0];
        end else if (r_op == OP_SB) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_word[7:0];
                2'd1:    w_merged[15:8]  = r_word[7:0];
                2'd2:    w_merged[23:16] = r_word[7:0];
                default: w_merged[31:24] = r_word[7:0];
            endcase
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            r_rdata    <= 32'h0;
            r_op       <= OP_LW;
            r_addr     <= 32'h0;
            r_word     <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_req) begin
                        r_op       <= i_op;
                        r_addr     <= i_addr;
                        // r_word holds the store data until RD turns it into the merged word
                        r_word     <= i_wdata;
                        r_rdata    <= 32'h0;
                        r_ready    <= 1'b0;
                        if (w_out_of_range || w_misaligned) begin
                            r_addr_err <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_addr_err <= 1'b0;
                            r_state    <= (i_op == OP_SW) ? S_WR : S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (w_is_load) begin
                        r_rdata <= w_load_val;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_word  <= w_merged;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port is quiet outside RD/WR; the write strobe is masked by reset
    // so an operation interrupted in WR never lands a partial write.
    assign o_dm_we    = (r_state == S_WR) && !reset;
    assign o_dm_addr  = (r_state == S_RD || r_state == S_WR) ? {r_addr[31:2], 2'b00} : 32'h0;
    assign o_dm_din   = (r_state == S_WR) ? r_word : 32'h0;

    assign o_ready    = r_ready;
    assign o_done     = r_done;
    assign o_rdata    = r_rdata;
    assign o_addr_err = r_addr_err;
    assign o_state    = r_state;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed scenarios plus randomized traffic checked
// against a byte-level reference model of the data memory.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_ready, o_done, o_addr_err, o_dm_we;
  logic [31:0] o_rdata, o_dm_addr, o_dm_din, i_dm_dout;
  logic [1:0]  o_state;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  dm_access_ctrl #(.ADDR_BITS(12)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_op(i_op), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_ready(o_ready), .o_done(o_done), .o_rdata(o_rdata),
    .o_addr_err(o_addr_err), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr),
    .o_dm_din(o_dm_din), .i_dm_dout(i_dm_dout), .o_state(o_state)
  );

  // data memory attached to the DUT
  logic [31:0] dm_mem [0:1023] = '{default: 32'h0};
  always @(posedge clk) if (o_dm_we) dm_mem[o_dm_addr[11:2]] <= o_dm_din;
  assign i_dm_dout = dm_mem[o_dm_addr[11:2]];

  // reference model state
  logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

  function automatic void ref_exec(input logic [2:0] op, input logic [31:0] addr,
                                   input logic [31:0] wdata, output logic [31:0] rd,
                                   output logic err, output int lat);
    int size;
    logic [31:0] word, mask, v;
    int shift;
    size = (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
    err = (addr >= 32'h1000) || ((addr % size) != 0);
    rd = 32'h0;
    lat = 1;
    if (err) return;
    word  = ref_mem[addr[11:2]];
    shift = int'(addr % 4) * 8;
    mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (size * 8)) - 32'h1);
    if (op <= 3'd4) begin
      v = (word >> shift) & mask;
      if ((op == 3'd1 || op == 3'd3) && v[size * 8 - 1]) v = v | ~mask;
      rd  = v;
      lat = 2;
    end else begin
      ref_mem[addr[11:2]] = (word & ~(mask << shift)) | ((wdata & mask) << shift);
      lat = (size == 4) ? 2 : 3;
    end
  endfunction

  // observations from the last driven request
  logic [31:0] obs_rdata;
  logic        obs_err, obs_post_ready, obs_post_done, obs_bad_addr;
  int          obs_lat, obs_we_cnt;

  // driver: one request through the handshake, records what the DUT did
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!o_ready && guard < 20) begin @(negedge clk); guard++; end
    i_req = 1'b1; i_op = op; i_addr = addr; i_wdata = wdata;
    @(negedge clk);
    i_req = 1'b0;
    obs_lat = 1; obs_we_cnt = 0; obs_bad_addr = 1'b0;
    while (!o_done && obs_lat <= 10) begin
      if (o_dm_we) begin
        obs_we_cnt++;
        if (o_dm_addr !== {addr[31:2], 2'b00}) obs_bad_addr = 1'b1;
      end
      @(negedge clk);
      obs_lat++;
    end
    obs_rdata = o_rdata;
    obs_err   = o_addr_err;
    @(negedge clk);
    obs_post_ready = o_ready;
    obs_post_done  = o_done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
    n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b exp=0", o_done); end
    n_vec++; if (o_addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err got=%0b exp=0", o_addr_err); end
    n_vec++; if (o_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", o_rdata); end
    n_vec++; if (o_dm_we !== 1'b0) begin n_err++; $display("FAIL reset_dm_we got=%0b exp=0", o_dm_we); end
    n_vec++; if (o_dm_addr !== 32'h0 || o_dm_din !== 32'h0) begin n_err++; $display("FAIL reset_dm_bus got addr=%h din=%h exp=0/0", o_dm_addr, o_dm_din); end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic err; int lat;
    run_req(3'd5, 32'h10, 32'hDEADBEEF);
    ref_exec(3'd5, 32'h10, 32'hDEADBEEF, rd, err, lat);
    n_vec++; if (obs_lat !== 2) begin n_err++; $display("FAIL sw_latency got=%0d exp=2", obs_lat); end
    n_vec++; if (obs_we_cnt !== 1 || obs_bad_addr) begin n_err++; $display("FAIL sw_we got=%0d bad_addr=%0b exp=1/0", obs_we_cnt, obs_bad_addr); end
    n_vec++; if (dm_mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_mem got=%h exp=deadbeef", dm_mem[4]); end
    n_vec++; if (obs_rdata !== 32'h0 || obs_err !== 1'b0) begin n_err++; $display("FAIL sw_result got rdata=%h err=%0b exp=0/0", obs_rdata, obs_err); end
    n_vec++; if (obs_post_ready !== 1'b1 || obs_post_done !== 1'b0) begin n_err++; $display("FAIL sw_done_pulse got ready=%0b done=%0b exp=1/0", obs_post_ready, obs_post_done); end
    run_req(3'd0, 32'h10, 32'h0);
    ref_exec(3'd0, 32'h10, 32'h0, rd, err, lat);
    n_vec++; if (obs_lat !== 2) begin n_err++; $display("FAIL lw_latency got=%0d exp=2", obs_lat); end
    n_vec++; if (obs_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata got=%h exp=deadbeef", obs_rdata); end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic err; int lat;
    run_req(3'd7, 32'h11, 32'h55);
    ref_exec(3'd7, 32'h11, 32'h55, rd, err, lat);
    n_vec++; if (obs_lat !== 3) begin n_err++; $display("FAIL sb_latency got=%0d exp=3", obs_lat); end
    n_vec++; if (dm_mem[4] !== 32'hDEAD55EF) begin n_err++; $display("FAIL sb_mem got=%h exp=dead55ef", dm_mem[4]); end
    run_req(3'd6, 32'h12, 32'hFFFF1234);
    ref_exec(3'd6, 32'h12, 32'hFFFF1234, rd, err, lat);
    n_vec++; if (obs_lat !== 3 || obs_we_cnt !== 1) begin n_err++; $display("FAIL sh_timing got lat=%0d we=%0d exp=3/1", obs_lat, obs_we_cnt); end
    n_vec++; if (dm_mem[4] !== 32'h123455EF) begin n_err++; $display("FAIL sh_mem got=%h exp=123455ef", dm_mem[4]); end
  endtask

  task automatic test_extension();
    logic [2:0]  ops  [8] = '{3'd3, 3'd3, 3'd4, 3'd1, 3'd2, 3'd1, 3'd4, 3'd0};
    logic [31:0] offs [8] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'd3, 32'd0};
    logic [31:0] exps [8] = '{32'h0000007F, 32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001,
                              32'h00008001, 32'hFFFFF07F, 32'h00000080, 32'h8001F07F};
    logic [31:0] rd; logic err; int lat;
    run_req(3'd5, 32'h30, 32'h8001F07F);
    ref_exec(3'd5, 32'h30, 32'h8001F07F, rd, err, lat);
    for (int i = 0; i < 8; i++) begin
      run_req(ops[i], 32'h30 + offs[i], $urandom);
      n_vec++;
      if (obs_rdata !== exps[i] || obs_lat !== 2 || obs_err !== 1'b0) begin
        n_err++;
        $display("FAIL ext_%0d op=%0d got rdata=%h lat=%0d err=%0b exp=%h/2/0", i, ops[i], obs_rdata, obs_lat, obs_err, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0]  ops  [3] = '{3'd0, 3'd6, 3'd5};
    logic [31:0] adrs [3] = '{32'h13, 32'h11, 32'h1000};
    for (int i = 0; i < 3; i++) begin
      run_req(ops[i], adrs[i], $urandom);
      n_vec++;
      if (obs_lat !== 1 || obs_err !== 1'b1 || obs_we_cnt !== 0 || obs_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL err_%0d got lat=%0d err=%0b we=%0d rdata=%h exp=1/1/0/0", i, obs_lat, obs_err, obs_we_cnt, obs_rdata);
      end
    end
    n_vec++; if (dm_mem[4] !== 32'h123455EF || dm_mem[0] !== 32'h0) begin n_err++; $display("FAIL err_mem got w4=%h w0=%h exp=123455ef/0", dm_mem[4], dm_mem[0]); end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [31:0] rd; logic err; int lat;
    @(negedge clk);
    i_req = 1'b1; i_op = 3'd7; i_addr = 32'h20; i_wdata = 32'hA5;
    @(negedge clk); i_req = 1'b0;
    @(negedge clk);
    n_vec++; if (o_dm_we !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_wr got we=%0b exp=1", o_dm_we); end
    reset = 1'b1;
    #1;
    n_vec++; if (o_dm_we !== 1'b0) begin n_err++; $display("FAIL rst_mid_we_gated got=%0b exp=0", o_dm_we); end
    @(negedge clk); reset = 1'b0;
    n_vec++; if (o_ready !== 1'b1 || o_done !== 1'b0 || o_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_idle got ready=%0b done=%0b rdata=%h exp=1/0/0", o_ready, o_done, o_rdata); end
    n_vec++; if (dm_mem[8] !== 32'h0) begin n_err++; $display("FAIL rst_mid_mem got=%h exp=0", dm_mem[8]); end
    dones = 0;
    repeat (3) begin @(negedge clk); if (o_done) dones++; end
    // reset wins over a simultaneous request
    reset = 1'b1; i_req = 1'b1; i_op = 3'd0; i_addr = 32'h20;
    @(negedge clk); reset = 1'b0; i_req = 1'b0;
    repeat (3) begin @(negedge clk); if (o_done || !o_ready) dones++; end
    n_vec++; if (dones !== 0) begin n_err++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
    run_req(3'd0, 32'h20, 32'h0);
    ref_exec(3'd0, 32'h20, 32'h0, rd, err, lat);
    n_vec++; if (obs_rdata !== rd || obs_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_reload got=%h exp=0", obs_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] rd; logic err; int lat;
    int accepts, dones;
    accepts = 0; dones = 0;
    @(negedge clk);
    while (!o_ready) @(negedge clk);
    i_req = 1'b1; i_op = 3'd5; i_addr = 32'h40; i_wdata = $urandom;
    for (int i = 0; i < 30; i++) begin
      if (o_done) begin
        dones++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL b2b_extra_done got=done exp=none");
        end else begin
          rd = exp_q.pop_front();
          n_vec++; if (o_rdata !== rd) begin n_err++; $display("FAIL b2b_rdata got=%h exp=%h", o_rdata, rd); end
        end
      end
      if (o_ready) begin
        accepts++;
        ref_exec(i_op, i_addr, i_wdata, rd, err, lat);
        exp_q.push_back(rd);
        @(posedge clk); #1;
        i_op = (i_op == 3'd5) ? 3'd0 : 3'd5;
        i_wdata = $urandom;
      end
      @(negedge clk);
    end
    i_req = 1'b0;
    repeat (3) begin if (o_done) dones++; @(negedge clk); end
    n_vec++; if (accepts !== 10) begin n_err++; $display("FAIL b2b_accepts got=%0d exp=10", accepts); end
    n_vec++; if (dones !== accepts) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=%0d", dones, accepts); end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] addr, wdata, rd; logic err; int lat, exp_we;
    for (int i = 0; i < 120; i++) begin
      op    = 3'($urandom_range(0, 7));
      addr  = 32'($urandom_range(0, 255));
      wdata = $urandom;
      if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
      run_req(op, addr, wdata);
      ref_exec(op, addr, wdata, rd, err, lat);
      exp_we = (!err && op >= 3'd5) ? 1 : 0;
      n_vec++;
      if (obs_rdata !== rd || obs_err !== err || obs_lat !== lat || obs_we_cnt !== exp_we || obs_bad_addr) begin
        n_err++;
        $display("FAIL rand_%0d op=%0d addr=%h got rdata=%h err=%0b lat=%0d we=%0d exp=%h/%0b/%0d/%0d",
                 i, op, addr, obs_rdata, obs_err, obs_lat, obs_we_cnt, rd, err, lat, exp_we);
      end
    end
    for (int w = 0; w < 64; w++) begin
      n_vec++;
      if (dm_mem[w] !== ref_mem[w]) begin n_err++; $display("FAIL rand_mem_%0d got=%h exp=%h", w, dm_mem[w], ref_mem[w]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store_load();
    test_subword_store();
    test_extension();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Multi-cycle load/store controller that sits between the CPU datapath and the word-wide data memory. It accepts one memory request at a time over a req/ready/done handshake. It performs word, halfword and byte loads with sign or zero extension. It implements sub-word stores as read-modify-write on the word-only memory port, and it flags misaligned or out-of-range addresses without touching memory.

## Interface
- ADDR_BITS, 12, byte-address width backed by the DM (4 KiB, 1024 words); any set bit in addr[31:ADDR_BITS] is out of range
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- req  input  1  request strobe; sampled only when ready=1
- op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- addr  input  32  byte address
- wdata  input  32  store data; SH uses [15:0], SB uses [7:0]
- ready  output  1  controller idle, request accepted this cycle if req=1
- done  output  1  one-cycle completion pulse
- rdata  output  32  extended load result; valid from done, held until next accept
- addr_err  output  1  qualifies done: request aborted, no memory write
- dm_we  output  1  memory write enable (DM writes at posedge)
- dm_addr  output  32  word-aligned address {addr[31:2],2'b00} to DM
- dm_din  output  32  word to write
- dm_dout  input  32  DM combinational read data for dm_addr

## Operation
- Little-endian lanes: byte k = bits [8k+7:8k], k = addr[1:0]; halfword lane = addr[1] (bits [15:0] or [31:16]).
- States: IDLE, RD, WR, DONE.
- IDLE: ready=1. On req, latch op, addr, wdata; clear rdata to 0.
  - Error if out of range, or if alignment fails: LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]=1.
  - Error: go to DONE with addr_err latched 1.
  - Otherwise: LW/LH/LHU/LB/LBU/SH/SB go to RD; SW goes to WR.
- RD: drive dm_addr; capture dm_dout into word register.
  - Loads: rdata = selected lane; LH/LB sign-extend, LHU/LBU zero-extend; go to DONE.
  - SH/SB: go to WR.
- WR: dm_we=1; dm_addr driven.
  - dm_din = wdata for SW.
  - For SH/SB, dm_din = captured word with the selected lane replaced by wdata[15:0] / wdata[7:0]; other bytes preserved.
  - Go to DONE.
- DONE: done=1 for exactly one cycle; addr_err valid; next state IDLE.
- ready=0 in RD, WR, DONE. req in those states is ignored and not queued.
- Outside RD/WR: dm_addr=0, dm_din=0, dm_we=0.
- Stores leave rdata=0.

## Timing
- Request accepted at edge T (IDLE, req=1).
- LW/LH/LHU/LB/LBU: RD in cycle T+1; done in cycle T+2.
- SW: WR in cycle T+1, memory updated at the end of T+1; done in cycle T+2.
- SH/SB: RD in T+1, WR in T+2; done in T+3.
- Error: done with addr_err=1 in cycle T+1; dm_we never asserted.
- ready returns to 1 the cycle after done. Back-to-back requests are therefore spaced by at least one IDLE cycle.
- dm_we is a registered-state decode gated by reset: dm_we = (state==WR) && !reset.
- Reset values: state IDLE, ready=1, done=0, addr_err=0, rdata=0, dm_we=0, dm_addr=0, dm_din=0.
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. No partial write is issued in the reset cycle. The in-flight request is dropped and produces no done.
- Reset and req asserted together: reset wins; request not accepted.

## Test plan
- After reset, SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10:
  - done at T+2 for each.
  - DM word 4 = 0xDEADBEEF; rdata=0xDEADBEEF.
- With word 0x10 = 0xDEADBEEF:
  - SB addr=0x11 wdata=0x55 → word 0xDEAD55EF, done at T+3.
  - Then SH addr=0x12 wdata=0x1234 → word 0x123455EF.
- With word = 0x8001F07F:
  - LB addr+0 → 0x0000007F; LB addr+1 → 0xFFFFFFF0; LBU addr+1 → 0x000000F0.
  - LH addr+2 → 0xFFFF8001; LHU addr+2 → 0x00008001.
- Errors, each giving done+addr_err=1 at T+1, dm_we never high, memory unchanged:
  - LW addr=0x13
  - SH addr=0x11
  - SW addr=0x1000 (out of range at ADDR_BITS=12)
- Assert reset during the WR cycle of SB addr=0x20:
  - No write lands; next cycle ready=1, done=0.
  - Subsequent LW addr=0x20 returns the pre-reset-cleared memory value (0).
- Hold req=1 continuously with alternating LW/SW:
  - Each request is accepted only in IDLE.
  - No request is accepted or lost while busy; the done count equals the accept count.
